// File: rtl/opl3_slot_sequencer.sv
// OPL3 slot sequencer: divides clk down to the sample rate and sweeps every
// operator slot once per sample, one slot per clock, as stage-0 slot context.
module opl3_slot_sequencer #(
   parameter  int CLKS_PER_SAMPLE = 256,
   parameter  int NUM_BANKS       = 2,
   parameter  int OPS_PER_BANK    = 18,
   localparam int NUM_SLOTS       = NUM_BANKS * OPS_PER_BANK,
   localparam int BANK_W          = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
   localparam int OP_W            = $clog2(OPS_PER_BANK),
   localparam int IDX_W           = $clog2(NUM_SLOTS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run_en,
   output logic              sample_clk_en,
   output logic              slot_valid,
   output logic [BANK_W-1:0] bank_num,
   output logic [OP_W-1:0]   op_num,
   output logic [IDX_W-1:0]  slot_idx,
   output logic              last_slot
);

   localparam int CNT_W = $clog2(CLKS_PER_SAMPLE);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_SAMPLE - 1);
   localparam logic [OP_W-1:0]  OP_MAX  = OP_W'(OPS_PER_BANK - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_SLOTS - 1);

   if (CLKS_PER_SAMPLE <= NUM_SLOTS) begin : g_bad_clks
      $error("CLKS_PER_SAMPLE (%0d) must exceed NUM_SLOTS (%0d)", CLKS_PER_SAMPLE, NUM_SLOTS);
   end
   if (NUM_BANKS < 1 || OPS_PER_BANK < 2) begin : g_bad_geometry
      $error("NUM_BANKS must be >= 1 and OPS_PER_BANK >= 2");
   end

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  div_cnt;
   logic              valid_d;
   logic [BANK_W-1:0] bank_d;
   logic [OP_W-1:0]   op_d;
   logic [IDX_W-1:0]  idx_d;
   logic              last_d;

   // Next slot tuple; fields are forced to zero whenever the slot is not valid.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state;
      valid_d = 1'b0;
      bank_d  = '0;
      op_d    = '0;
      idx_d   = '0;
      last_d  = 1'b0;
      case (state)
         IDLE: begin
            if (sample_clk_en && run_en) begin
               state_d = RUN;
               valid_d = 1'b1;
            end
         end
         RUN: begin
            if (last_slot) begin
               state_d = IDLE;
            end else begin
               valid_d = 1'b1;
               idx_d   = slot_idx + 1'b1;
               last_d  = (idx_d == IDX_MAX);
               if (op_num == OP_MAX) begin
                  bank_d = bank_num + 1'b1;
               end else begin
                  bank_d = bank_num;
                  op_d   = op_num + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt       <= '0;
         sample_clk_en <= 1'b0;
         state         <= IDLE;
         slot_valid    <= 1'b0;
         bank_num      <= '0;
         op_num        <= '0;
         slot_idx      <= '0;
         last_slot     <= 1'b0;
      end else begin
         div_cnt       <= (div_cnt == CNT_MAX) ? '0 : div_cnt + 1'b1;
         sample_clk_en <= (div_cnt == CNT_MAX);
         state         <= state_d;
         slot_valid    <= valid_d;
         bank_num      <= bank_d;
         op_num        <= op_d;
         slot_idx      <= idx_d;
         last_slot     <= last_d;
      end
   end

endmodule

// File: tb/tb_opl3_slot_sequencer.sv
// Self-checking bench for opl3_slot_sequencer: segment table, corner-case
// sequences and randomized run_en/reset against a sample-level reference model.
module tb_opl3_slot_sequencer #(
   parameter int CLKS_PER_SAMPLE = 64,
   parameter int NUM_BANKS       = 2,
   parameter int OPS_PER_BANK    = 18
);

   localparam int N      = NUM_BANKS * OPS_PER_BANK;
   localparam int C      = CLKS_PER_SAMPLE;
   localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam int OP_W   = $clog2(OPS_PER_BANK);
   localparam int IDX_W  = $clog2(N);

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              run_en = 1'b0;
   logic              sample_clk_en;
   logic              slot_valid;
   logic [BANK_W-1:0] bank_num;
   logic [OP_W-1:0]   op_num;
   logic [IDX_W-1:0]  slot_idx;
   logic              last_slot;

   opl3_slot_sequencer #(
      .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE),
      .NUM_BANKS      (NUM_BANKS),
      .OPS_PER_BANK   (OPS_PER_BANK)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .run_en       (run_en),
      .sample_clk_en(sample_clk_en),
      .slot_valid   (slot_valid),
      .bank_num     (bank_num),
      .op_num       (op_num),
      .slot_idx     (slot_idx),
      .last_slot    (last_slot)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic              tick;
      logic              valid;
      logic [BANK_W-1:0] bank;
      logic [OP_W-1:0]   op;
      logic [IDX_W-1:0]  idx;
      logic              last;
   } obs_t;

   typedef struct {
      string name;
      bit    rst_n;
      bit    run;
      int    ncyc;
      int    ticks;
      int    valids;
      int    lasts;
   } seg_t;

   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   n_since_rst = 0;
   bit   prev_tick = 1'b0;
   int   slot_q[$];
   int   seg_ticks, seg_valid, seg_last;
   int   last_cyc = 0;
   int   gap = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One clock: model predicts this cycle's outputs from the slot schedule, DUT is sampled at negedge.
   task automatic step();
      logic r, e;
      bit   exp_tick;
      obs_t exp, act;
      r = reset_n;
      e = run_en;
      @(posedge clk);
      @(negedge clk);
      cyc++;
      exp_tick = 1'b0;
      if (!r) begin
         n_since_rst = 0;
         slot_q.delete();
      end else begin
         if (prev_tick && e) begin
            if (slot_q.size() != 0) check("sweep_overlap", 64'(slot_q.size()), 64'd0);
            for (int k = 0; k < N; k++) slot_q.push_back(k);
         end
         n_since_rst++;
         exp_tick = (n_since_rst % C == 0);
      end
      exp = '0;
      exp.tick = exp_tick;
      if (slot_q.size() > 0) begin
         int k;
         k = slot_q.pop_front();
         exp.valid = 1'b1;
         exp.bank  = BANK_W'(k / OPS_PER_BANK);
         exp.op    = OP_W'(k % OPS_PER_BANK);
         exp.idx   = IDX_W'(k);
         exp.last  = (k == N - 1);
      end
      act.tick  = sample_clk_en;
      act.valid = slot_valid;
      act.bank  = bank_num;
      act.op    = op_num;
      act.idx   = slot_idx;
      act.last  = last_slot;
      check($sformatf("cycle%0d", cyc), 64'(act), 64'(exp));
      prev_tick = exp_tick;
      if (sample_clk_en === 1'b1) seg_ticks++;
      if (slot_valid === 1'b1) begin
         seg_valid++;
         if (slot_idx == '0 && last_cyc > 0) gap = cyc - last_cyc - 1;
      end
      if (last_slot === 1'b1) begin
         seg_last++;
         last_cyc = cyc;
      end
   endtask

   task automatic clear_counts();
      seg_ticks = 0;
      seg_valid = 0;
      seg_last  = 0;
   endtask

   seg_t segs[4];

   initial begin
      bit found;

      // Segments run back to back; run_en set at a segment start governs the tick in progress.
      segs[0] = '{"reset_hold", 1'b0, 1'b0, 5,     0, 0,     0};
      segs[1] = '{"idle_run0",  1'b1, 1'b0, 3 * C, 3, 0,     0};
      segs[2] = '{"four_sweeps",1'b1, 1'b1, 4 * C, 4, 4 * N, 4};
      segs[3] = '{"tick_no_run",1'b1, 1'b0, C,     1, 0,     0};

      for (int s = 0; s < 4; s++) begin
         reset_n = segs[s].rst_n;
         run_en  = segs[s].run;
         clear_counts();
         for (int i = 0; i < segs[s].ncyc; i++) step();
         check({segs[s].name, "_ticks"},  64'(seg_ticks), 64'(segs[s].ticks));
         check({segs[s].name, "_valids"}, 64'(seg_valid), 64'(segs[s].valids));
         check({segs[s].name, "_lasts"},  64'(seg_last),  64'(segs[s].lasts));
         if (s == 2) check("sweep_gap", 64'(gap), 64'(C - N));
      end

      // run_en high only during the tick cycle still yields a full sweep.
      found = 1'b0;
      for (int i = 0; i < 2 * C && !found; i++) begin
         step();
         found = (sample_clk_en === 1'b1);
      end
      check("pulse_tick_found", 64'(found), 64'd1);
      run_en = 1'b1;
      clear_counts();
      step();
      run_en = 1'b0;
      for (int i = 1; i < C; i++) step();
      check("pulse_valids", 64'(seg_valid), 64'(N));
      check("pulse_lasts",  64'(seg_last),  64'd1);
      check("pulse_ticks",  64'(seg_ticks), 64'd1);
      clear_counts();
      for (int i = 0; i < C; i++) step();
      check("after_pulse_valids", 64'(seg_valid), 64'd0);

      // Reset in the middle of a sweep aborts it with no stale slots afterwards.
      run_en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 2 * C + N && !found; i++) begin
         step();
         found = (slot_valid === 1'b1 && slot_idx == IDX_W'(10));
      end
      check("abort_slot10_found", 64'(found), 64'd1);
      reset_n = 1'b0;
      step();
      check("abort_zero", 64'({sample_clk_en, slot_valid, bank_num, op_num, slot_idx, last_slot}), 64'd0);
      step();
      reset_n = 1'b1;
      clear_counts();
      for (int i = 0; i < C - 1; i++) step();
      check("abort_no_stale", 64'(seg_valid + seg_ticks), 64'd0);
      step();
      check("abort_first_tick", 64'(sample_clk_en), 64'd1);

      // Randomized run_en with occasional resets against the reference model.
      for (int i = 0; i < 2000; i++) begin
         run_en  = 1'($urandom_range(0, 1));
         reset_n = ($urandom_range(0, 149) != 0);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
